// File: rtl/gcd_core.sv
// gcd_core: iterative subtraction-based GCD engine.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   core can accept operands (high only in IDLE)
//   in_a/in_b  operands, WIDTH bits each
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_result gcd(in_a, in_b)
//   out_steps  number of subtraction steps performed (saturating)
//
// Each CALC cycle makes one decision: finish, or replace the larger operand
// with the difference. Zero or equal operands finish without any step.
module gcd_core #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [STEP_W-1:0] out_steps
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [STEP_W-1:0]   steps_q;

  logic                a_zero, b_zero, a_eq_b, a_gt_b;
  logic [WIDTH-1:0]    diff_ab, diff_ba;
  logic [STEP_W-1:0]   steps_inc;

  always_comb begin
    a_zero  = (a_q == '0);
    b_zero  = (b_q == '0);
    a_eq_b  = (a_q == b_q);
    a_gt_b  = (a_q > b_q);
    // Only the larger-minus-smaller difference is ever loaded, so no underflow.
    diff_ab = a_q - b_q;
    diff_ba = b_q - a_q;
    // Saturate at all-ones instead of wrapping.
    steps_inc = (&steps_q) ? steps_q : steps_q + 1'b1;
  end

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      steps_q    <= '0;
      out_result <= '0;
      out_steps  <= '0;
      out_valid  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            steps_q <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (a_zero || b_zero || a_eq_b) begin
            // a==0 yields b; otherwise a (covers b==0 and a==b).
            out_result <= a_zero ? b_q : a_q;
            out_steps  <= steps_q;
            out_valid  <= 1'b1;
            state_q    <= StDone;
          end else if (a_gt_b) begin
            a_q     <= diff_ab;
            steps_q <= steps_inc;
          end else begin
            b_q     <= diff_ba;
            steps_q <= steps_inc;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_core.sv
// tb_gcd_core: self-checking bench for gcd_core. Directed cases plus random
// operand pairs, checked against a Euclid-based reference model.
module tb_gcd_core;

  localparam int unsigned WIDTH  = 32;
  // Narrow step counter so saturation is reachable in a short run.
  localparam int unsigned STEP_W = 6;
  localparam longint unsigned STEP_MAX = (64'd1 << STEP_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [STEP_W-1:0] out_steps;

  gcd_core #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_steps  (out_steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Subtractive GCD step count derived from Euclid quotients: a quotient q with
  // nonzero remainder costs q subtractions; the final exact division costs q-1
  // (the loop stops once both operands are equal).
  function automatic void gcd_model(input longint unsigned a, input longint unsigned b,
                                    output longint unsigned g, output longint unsigned n);
    longint unsigned x, y, t, q, r;
    bit done;
    x = a; y = b; n = 0; g = 0; done = 0;
    if (x == 0) begin g = y; done = 1; end
    else if (y == 0) begin g = x; done = 1; end
    while (!done) begin
      if (x < y) begin t = x; x = y; y = t; end
      q = x / y;
      r = x % y;
      if (r == 0) begin
        n = n + q - 1;
        g = y;
        done = 1;
      end else begin
        n = n + q;
        x = r;
      end
    end
  endfunction

  // Entered and left at #1 after a rising edge with the core in IDLE.
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    longint unsigned g, n, exp_steps;
    int cycles;
    logic [WIDTH-1:0] held_res;
    gcd_model(a, b, g, n);
    exp_steps = (n > STEP_MAX) ? STEP_MAX : n;
    check_eq("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    check_eq("busy_ready", in_ready, 0);
    cycles = 0;
    while (!out_valid && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq("latency", cycles, n + 1);
    check_eq("result", out_result, g);
    check_eq("steps", out_steps, exp_steps);
    if (hold > 0) begin
      held_res = out_result;
      in_valid = 1'b1;
      in_a     = 30;
      in_b     = 12;
      repeat (hold) begin
        @(posedge clk); #1;
        check_eq("bp_valid", out_valid, 1);
        check_eq("bp_result", out_result, g);
        check_eq("bp_steps", out_steps, exp_steps);
        check_eq("bp_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("valid_drop", out_valid, 0);
    check_eq("ready_after", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    longint unsigned g, n;
    bit saw_valid;

    // Reset with a valid operand pair already presented.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 12;
    in_b      = 8;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_steps", out_steps, 0);
    check_eq("rst_ready", in_ready, 1);
    rst = 1'b0;
    #1;
    check_eq("rst_no_accept", in_ready, 1);
    @(posedge clk); #1;
    check_eq("accept_after_rst", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    run_txn(12, 8, 0);
    run_txn(0, 9, 0);
    run_txn(9, 0, 0);
    run_txn(0, 0, 0);
    run_txn(7, 7, 0);
    run_txn(17, 5, 0);
    run_txn(48, 18, 0);
    run_txn(48, 18, 5);
    run_txn(30, 12, 0);
    // Step counter around the saturation point.
    run_txn(63, 1, 0);
    run_txn(64, 1, 0);
    run_txn(200, 1, 0);

    // Reset in the middle of a computation.
    in_valid = 1'b1;
    in_a     = 17;
    in_b     = 5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_result", out_result, 0);
    check_eq("mid_rst_steps", out_steps, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("mid_rst_no_valid", saw_valid, 0);
    run_txn(12, 8, 0);

    // Random operand pairs, bounded in step count.
    for (int i = 0; i < 60; i++) begin
      do begin
        if ($urandom_range(0, 1) == 0) begin
          ra = $urandom_range(0, 300);
          rb = $urandom_range(0, 300);
        end else begin
          ra = $urandom;
          rb = $urandom;
        end
        gcd_model(ra, rb, g, n);
      end while (n > 600);
      run_txn(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_core.md
Name: gcd_core

Overview:
- Iterative subtraction-based GCD engine for the GCD_SystemVerilog design.
- Holds the A/B operand registers and the controller FSM.
- Each cycle it selects, through the 32-bit 2:1 select muxes, whether each operand register keeps its value, loads new data or loads its difference.
- Valid/ready handshake on input and on output.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STEP_W, 32, width of the subtraction-step counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  core can accept operands; high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  gcd(A,B).
- out_steps  output  STEP_W  number of subtraction steps performed.

Behaviour:
- Reset:
  - Asynchronous on rst high.
  - state=IDLE; reg_a, reg_b, out_result, out_steps = 0; out_valid=0.
  - in_ready=1 once in IDLE, including during reset.
- States: IDLE, CALC, DONE (registered FSM).
- in_ready is combinational: state==IDLE. out_valid is registered: state==DONE.
- IDLE:
  - On in_valid & in_ready: reg_a<=in_a, reg_b<=in_b, step counter<=0, go CALC.
  - Otherwise hold.
- CALC, one decision per cycle, priority order:
  - reg_a==0: out_result<=reg_b, go DONE.
  - reg_b==0: out_result<=reg_a, go DONE.
  - reg_a==reg_b: out_result<=reg_a, go DONE.
  - reg_a>reg_b: reg_a<=reg_a-reg_b, steps+1, stay.
  - reg_b>reg_a: reg_b<=reg_b-reg_a, steps+1, stay.
- Arithmetic:
  - Unsigned WIDTH-bit compare and subtract.
  - Subtraction only ever occurs larger minus smaller, so there is no underflow.
- Step counter:
  - Saturates at all-ones and does not wrap.
  - out_steps is loaded with the counter value on entry to DONE.
- Latency:
  - out_valid rises N+1 cycles after the accepting edge, where N = subtraction steps.
  - gcd(0,x), gcd(x,0) and gcd(x,x) take N=0, i.e. 1 cycle.
- DONE:
  - out_valid=1; out_result and out_steps held stable.
  - On out_ready: go IDLE.
  - in_ready=0 in DONE, so a new operand pair cannot be accepted on the same edge as result acceptance. The earliest next accept is the following cycle.
- Operand inputs in_a/in_b/in_valid are ignored outside IDLE.
- out_ready while not DONE has no effect.
- Reset mid-CALC or mid-DONE: immediate return to the reset state. No out_valid pulse; the partial result is discarded.
- gcd(0,0)=0 with out_steps=0.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, out_result=0. First acceptance occurs only after rst deasserts.
- in_a=12, in_b=8, out_ready=1:
  - Sequence (12,8)->(4,8)->(4,4).
  - out_valid high exactly 3 cycles after the accept edge, out_result=4, out_steps=2.
  - in_ready=1 the cycle after the handshake.
- Zero and equal operand cases -> out_valid 1 cycle after accept, out_steps=0:
  - (0,9) -> 9.
  - (9,0) -> 9.
  - (0,0) -> 0.
  - (7,7) -> 7.
- Coprime and multi-step cases:
  - (17,5) -> out_result=1, out_steps=6, out_valid 7 cycles after accept.
  - (48,18) -> out_result=6, out_steps=4.
- Backpressure on (48,18):
  - Hold out_ready=0 for 5 cycles, driving in_valid=1 with new operands throughout.
  - out_valid stays 1, result 6 held stable, in_ready=0, new operands ignored.
  - Raise out_ready -> IDLE next cycle, then accept the new pair.
- Reset mid-CALC: start (17,5), pulse rst at cycle 3 -> all outputs 0 immediately, no out_valid. Next (12,8) completes normally with 4 and 2 steps.
